r1024x16_port_arbiter: RTL and testbench

R1024X16_PORT_ARBITER -- requirements
Module: r1024x16_port_arbiter

---
 rtl/r1024x16_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_r1024x16_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r1024x16_port_arbiter.sv
// Two-requester round-robin front end for a 1024x16 RAM with byte enables.
// After reset it can optionally sweep the whole RAM to zero before serving requests.
module r1024x16_port_arbiter #(
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int DEPTH          = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        A_Req,
    input  logic        B_Req,
    input  logic        A_We,
    input  logic        B_We,
    input  logic [9:0]  A_Addr,
    input  logic [9:0]  B_Addr,
    input  logic [15:0] A_WD,
    input  logic [15:0] B_WD,
    input  logic [1:0]  A_Ben,
    input  logic [1:0]  B_Ben,
    output logic        A_Gnt,
    output logic        B_Gnt,
    output logic        A_RValid,
    output logic        B_RValid,
    output logic [15:0] A_RD,
    output logic [15:0] B_RD,
    output logic [9:0]  WA,
    output logic [15:0] WD,
    output logic [1:0]  WEN,
    output logic [9:0]  RA,
    input  logic [15:0] RD,
    output logic        Busy
);

    localparam int AW = 10;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clrCnt;
    logic            r_prioA;
    logic            r_aRValid;
    logic            r_bRValid;
    logic [15:0]     r_aRdHold;
    logic [15:0]     r_bRdHold;
    logic [AW-1:0]   r_waHold;
    logic [15:0]     r_wdHold;
    logic [AW-1:0]   r_raHold;

    logic            w_run;
    logic            w_aGnt;
    logic            w_bGnt;
    logic            w_gntWe;
    logic [AW-1:0]   w_gntAddr;
    logic [15:0]     w_gntWd;
    logic [1:0]      w_gntBen;
    logic            w_wrGnt;
    logic            w_rdGnt;

    // Grant is decided combinationally so a request is accepted in the cycle it appears.
    always_comb begin
        w_run     = (r_state == RUN);
        w_aGnt    = w_run & A_Req & (~B_Req | r_prioA);
        w_bGnt    = w_run & B_Req & (~A_Req | ~r_prioA);
        w_gntWe   = w_aGnt ? A_We   : B_We;
        w_gntAddr = w_aGnt ? A_Addr : B_Addr;
        w_gntWd   = w_aGnt ? A_WD   : B_WD;
        w_gntBen  = w_aGnt ? A_Ben  : B_Ben;
        w_wrGnt   = (w_aGnt | w_bGnt) & w_gntWe;
        w_rdGnt   = (w_aGnt | w_bGnt) & ~w_gntWe;
    end

    always_comb begin
        A_Gnt    = w_aGnt;
        B_Gnt    = w_bGnt;
        Busy     = ~w_run;
        WA       = r_waHold;
        WD       = r_wdHold;
        WEN      = 2'b00;
        if (!w_run) begin
            WA  = r_clrCnt;
            WD  = 16'h0000;
            WEN = 2'b11;
        end else if (w_wrGnt) begin
            WA  = w_gntAddr;
            WD  = w_gntWd;
            WEN = w_gntBen;
        end
        RA       = w_rdGnt ? w_gntAddr : r_raHold;
        A_RValid = r_aRValid;
        B_RValid = r_bRValid;
        // The RAM output is only meaningful in the response cycle; otherwise replay the last delivery.
        A_RD     = r_aRValid ? RD : r_aRdHold;
        B_RD     = r_bRValid ? RD : r_bRdHold;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= CLEAR_ON_RESET ? CLEAR : RUN;
            r_clrCnt  <= '0;
            r_prioA   <= 1'b1;
            r_aRValid <= 1'b0;
            r_bRValid <= 1'b0;
            r_aRdHold <= 16'h0000;
            r_bRdHold <= 16'h0000;
            r_waHold  <= '0;
            r_wdHold  <= 16'h0000;
            r_raHold  <= '0;
        end else begin
            r_waHold  <= WA;
            r_wdHold  <= WD;
            r_raHold  <= RA;
            r_aRValid <= w_aGnt & ~A_We;
            r_bRValid <= w_bGnt & ~B_We;
            if (r_aRValid) begin
                r_aRdHold <= RD;
            end
            if (r_bRValid) begin
                r_bRdHold <= RD;
            end
            if (r_state == CLEAR) begin
                if (r_clrCnt == AW'(DEPTH - 1)) begin
                    r_state  <= RUN;
                    r_clrCnt <= '0;
                end else begin
                    r_clrCnt <= r_clrCnt + 1'b1;
                end
            end else begin
                // Priority always moves to the requester that was not just served.
                if (w_aGnt) begin
                    r_prioA <= 1'b0;
                end else if (w_bGnt) begin
                    r_prioA <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_r1024x16_port_arbiter.sv
// Self-checking bench for r1024x16_port_arbiter: clear sweep, directed vectors,
// randomized traffic against a shadow-memory reference model, and reset corner cases.
module tb_r1024x16_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        A_Req, B_Req, A_We, B_We;
    logic [9:0]  A_Addr, B_Addr;
    logic [15:0] A_WD, B_WD;
    logic [1:0]  A_Ben, B_Ben;
    logic        A_Gnt, B_Gnt, A_RValid, B_RValid;
    logic [15:0] A_RD, B_RD;
    logic [9:0]  WA, RA;
    logic [15:0] WD, RD;
    logic [1:0]  WEN;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    r1024x16_port_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .A_Req(A_Req), .B_Req(B_Req), .A_We(A_We), .B_We(B_We),
        .A_Addr(A_Addr), .B_Addr(B_Addr), .A_WD(A_WD), .B_WD(B_WD),
        .A_Ben(A_Ben), .B_Ben(B_Ben), .A_Gnt(A_Gnt), .B_Gnt(B_Gnt),
        .A_RValid(A_RValid), .B_RValid(B_RValid), .A_RD(A_RD), .B_RD(B_RD),
        .WA(WA), .WD(WD), .WEN(WEN), .RA(RA), .RD(RD), .Busy(Busy)
    );

    // Attached RAM: byte-enabled write, registered read; primed with non-zero garbage.
    logic [15:0] ramMem [1024];
    logic [15:0] ramRd;
    logic        ramPrimed = 1'b0;
    assign RD = ramRd;

    always @(posedge Clk) begin
        if (!ramPrimed) begin
            for (int i = 0; i < 1024; i++) ramMem[i] <= 16'hDEAD ^ 16'(i);
            ramPrimed <= 1'b1;
        end else begin
            if (WEN[0]) ramMem[WA][7:0]  <= WD[7:0];
            if (WEN[1]) ramMem[WA][15:8] <= WD[15:8];
        end
        ramRd <= ramMem[RA];
    end

    typedef struct {
        logic aReq; logic aWe; logic [9:0] aAddr; logic [15:0] aWd; logic [1:0] aBen;
        logic bReq; logic bWe; logic [9:0] bAddr; logic [15:0] bWd; logic [1:0] bBen;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        expAGnt;
        logic        expBGnt;
        logic [1:0]  expWen;
        logic        expAValid;
        logic        expBValid;
        logic [15:0] expRd;
    } vec_t;

    // Reference model state: priority holder, shadow RAM, pending responses.
    logic        mPrioA;
    logic [15:0] mMem [1024];
    logic [9:0]  mRa;
    logic        mPendA, mPendB;
    logic [15:0] mPendData, mHoldA, mHoldB;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input stim_t s);
        A_Req = s.aReq; A_We = s.aWe; A_Addr = s.aAddr; A_WD = s.aWd; A_Ben = s.aBen;
        B_Req = s.bReq; B_We = s.bWe; B_Addr = s.bAddr; B_WD = s.bWd; B_Ben = s.bBen;
    endtask

    function automatic stim_t mkStim(bit aReq, bit aWe, int aAddr, int aWd, int aBen,
                                     bit bReq, bit bWe, int bAddr, int bWd, int bBen);
        stim_t s;
        s.aReq = aReq; s.aWe = aWe; s.aAddr = 10'(aAddr); s.aWd = 16'(aWd); s.aBen = 2'(aBen);
        s.bReq = bReq; s.bWe = bWe; s.bAddr = 10'(bAddr); s.bWd = 16'(bWd); s.bBen = 2'(bBen);
        return s;
    endfunction

    function automatic vec_t mkVec(stim_t s, bit eA, bit eB, int eWen, bit rvA, bit rvB, int rd);
        vec_t v;
        v.s = s; v.expAGnt = eA; v.expBGnt = eB; v.expWen = 2'(eWen);
        v.expAValid = rvA; v.expBValid = rvB; v.expRd = 16'(rd);
        return v;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.aReq  = 1'($urandom_range(0, 1));
        s.aWe   = 1'($urandom_range(0, 1));
        s.aAddr = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom);
        s.aWd   = 16'($urandom);
        s.aBen  = 2'($urandom);
        s.bReq  = 1'($urandom_range(0, 1));
        s.bWe   = 1'($urandom_range(0, 1));
        s.bAddr = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom);
        s.bWd   = 16'($urandom);
        s.bBen  = 2'($urandom);
        return s;
    endfunction

    // Called at the negedge of a RUN cycle with the stimulus driven for that cycle.
    task automatic modelCycle(input stim_t s);
        logic        aG, bG, we;
        logic [9:0]  addr;
        logic [15:0] wd;
        logic [1:0]  ben;
        checkOutput("A_RValid", 32'(A_RValid), 32'(mPendA));
        checkOutput("B_RValid", 32'(B_RValid), 32'(mPendB));
        if (mPendA) mHoldA = mPendData;
        if (mPendB) mHoldB = mPendData;
        checkOutput("A_RD", 32'(A_RD), 32'(mHoldA));
        checkOutput("B_RD", 32'(B_RD), 32'(mHoldB));
        checkOutput("Busy_run", 32'(Busy), 32'(0));
        aG = s.aReq && (!s.bReq || mPrioA);
        bG = s.bReq && (!s.aReq || !mPrioA);
        checkOutput("A_Gnt", 32'(A_Gnt), 32'(aG));
        checkOutput("B_Gnt", 32'(B_Gnt), 32'(bG));
        mPendA = 1'b0;
        mPendB = 1'b0;
        if (aG || bG) begin
            we   = aG ? s.aWe   : s.bWe;
            addr = aG ? s.aAddr : s.bAddr;
            wd   = aG ? s.aWd   : s.bWd;
            ben  = aG ? s.aBen  : s.bBen;
            if (we) begin
                checkOutput("WEN_wr", 32'(WEN), 32'(ben));
                checkOutput("WA_wr", 32'(WA), 32'(addr));
                checkOutput("WD_wr", 32'(WD), 32'(wd));
                checkOutput("RA_hold", 32'(RA), 32'(mRa));
                if (ben[0]) mMem[addr][7:0]  = wd[7:0];
                if (ben[1]) mMem[addr][15:8] = wd[15:8];
            end else begin
                checkOutput("WEN_rd", 32'(WEN), 32'(0));
                checkOutput("RA_rd", 32'(RA), 32'(addr));
                mRa       = addr;
                mPendA    = aG;
                mPendB    = bG;
                mPendData = mMem[addr];
            end
            mPrioA = bG;
        end else begin
            checkOutput("WEN_idle", 32'(WEN), 32'(0));
            checkOutput("RA_idle", 32'(RA), 32'(mRa));
        end
    endtask

    // Walks n clear cycles starting at counter value 'start', ending just after the last edge.
    task automatic clearScan(input int start, input int n, output int errs);
        errs = 0;
        for (int i = start; i < start + n; i++) begin
            @(negedge Clk);
            if (WA !== 10'(i) || WEN !== 2'b11 || WD !== 16'h0000 || Busy !== 1'b1 ||
                A_Gnt !== 1'b0 || B_Gnt !== 1'b0 || A_RValid !== 1'b0 || B_RValid !== 1'b0) begin
                if (errs == 0)
                    $display("[TB] FAIL clear_step %0d: WA=%0h WEN=%0h WD=%0h Busy=%0b Gnt=%0b%0b", i, WA, WEN, WD, Busy, A_Gnt, B_Gnt);
                errs++;
            end
            tick();
        end
    endtask

    vec_t tbl [11];

    initial begin
        int errs;

        applyStimulus(mkStim(1, 0, 3, 0, 0, 1, 0, 4, 0, 0));
        Rst = 1'b1;
        tick();
        Rst = 1'b0;

        // First cycle after reset: clear has begun at address 0, nothing granted.
        @(negedge Clk);
        checkOutput("rst_Busy", 32'(Busy), 32'(1));
        checkOutput("rst_WA", 32'(WA), 32'(0));
        checkOutput("rst_WEN", 32'(WEN), 32'(3));
        checkOutput("rst_WD", 32'(WD), 32'(0));
        checkOutput("rst_RA", 32'(RA), 32'(0));
        checkOutput("rst_A_Gnt", 32'(A_Gnt), 32'(0));
        checkOutput("rst_B_Gnt", 32'(B_Gnt), 32'(0));
        checkOutput("rst_A_RValid", 32'(A_RValid), 32'(0));
        checkOutput("rst_B_RValid", 32'(B_RValid), 32'(0));
        checkOutput("rst_A_RD", 32'(A_RD), 32'(0));
        checkOutput("rst_B_RD", 32'(B_RD), 32'(0));
        tick();

        clearScan(1, 499, errs);
        checkOutput("clear_first_500", 32'(errs), 32'(0));

        // Reset while the sweep is at address 500; it must restart from 0.
        Rst = 1'b1;
        @(negedge Clk);
        checkOutput("clear_at_500_WA", 32'(WA), 32'(500));
        tick();
        Rst = 1'b0;
        clearScan(0, 1024, errs);
        checkOutput("clear_full_sweep", 32'(errs), 32'(0));

        mPrioA = 1'b1; mRa = 10'd0; mPendA = 1'b0; mPendB = 1'b0;
        mPendData = 16'h0; mHoldA = 16'h0; mHoldB = 16'h0;
        for (int i = 0; i < 1024; i++) mMem[i] = 16'h0000;

        tbl[0]  = mkVec(mkStim(1, 1, 5, 'h1234, 3, 0, 0, 0, 0, 0),          1, 0, 3, 0, 0, 0);
        tbl[1]  = mkVec(mkStim(0, 0, 0, 0, 0, 1, 0, 5, 0, 0),               0, 1, 0, 0, 1, 'h1234);
        tbl[2]  = mkVec(mkStim(1, 1, 9, 'h00AB, 1, 1, 0, 9, 0, 0),          1, 0, 1, 0, 0, 0);
        tbl[3]  = mkVec(mkStim(1, 0, 9, 0, 0, 1, 0, 5, 0, 0),               0, 1, 0, 0, 1, 'h1234);
        tbl[4]  = mkVec(mkStim(1, 0, 9, 0, 0, 1, 1, 7, 'hBEEF, 2),          1, 0, 0, 1, 0, 'h00AB);
        tbl[5]  = mkVec(mkStim(1, 0, 9, 0, 0, 1, 1, 7, 'hBEEF, 2),          0, 1, 2, 0, 0, 0);
        tbl[6]  = mkVec(mkStim(1, 1, 9, 'hFFFF, 0, 0, 0, 0, 0, 0),          1, 0, 0, 0, 0, 0);
        tbl[7]  = mkVec(mkStim(1, 0, 9, 0, 0, 0, 0, 0, 0, 0),               1, 0, 0, 1, 0, 'h00AB);
        tbl[8]  = mkVec(mkStim(0, 0, 0, 0, 0, 1, 1, 7, 'h1122, 1),          0, 1, 1, 0, 0, 0);
        tbl[9]  = mkVec(mkStim(0, 0, 0, 0, 0, 1, 0, 7, 0, 0),               0, 1, 0, 0, 1, 'hBE22);
        tbl[10] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),               0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].s);
            @(negedge Clk);
            modelCycle(tbl[i].s);
            checkOutput($sformatf("vec%0d_A_Gnt", i), 32'(A_Gnt), 32'(tbl[i].expAGnt));
            checkOutput($sformatf("vec%0d_B_Gnt", i), 32'(B_Gnt), 32'(tbl[i].expBGnt));
            checkOutput($sformatf("vec%0d_WEN", i), 32'(WEN), 32'(tbl[i].expWen));
            if (i > 0) begin
                checkOutput($sformatf("vec%0d_A_RValid", i - 1), 32'(A_RValid), 32'(tbl[i-1].expAValid));
                checkOutput($sformatf("vec%0d_B_RValid", i - 1), 32'(B_RValid), 32'(tbl[i-1].expBValid));
                if (tbl[i-1].expAValid)
                    checkOutput($sformatf("vec%0d_A_RD", i - 1), 32'(A_RD), 32'(tbl[i-1].expRd));
                if (tbl[i-1].expBValid)
                    checkOutput($sformatf("vec%0d_B_RD", i - 1), 32'(B_RD), 32'(tbl[i-1].expRd));
            end
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            stim_t s;
            s = randStim();
            applyStimulus(s);
            @(negedge Clk);
            modelCycle(s);
            tick();
        end

        // Read granted in the same cycle Rst is raised: its response must never appear.
        begin
            stim_t s;
            s = mkStim(1, 1, 5, 'h5A5A, 3, 0, 0, 0, 0, 0);
            applyStimulus(s);
            @(negedge Clk);
            modelCycle(s);
            tick();
            s = mkStim(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
            applyStimulus(s);
            @(negedge Clk);
            modelCycle(s);
            tick();
            applyStimulus(s);
            Rst = 1'b1;
            @(negedge Clk);
            modelCycle(s);
            checkOutput("pre_rst_A_RD", 32'(A_RD), 32'(16'h5A5A));
            tick();
            Rst = 1'b0;
            applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            @(negedge Clk);
            checkOutput("rst_drop_A_RValid", 32'(A_RValid), 32'(0));
            checkOutput("rst_drop_A_RD", 32'(A_RD), 32'(0));
            checkOutput("rst_drop_Busy", 32'(Busy), 32'(1));
            checkOutput("rst_drop_RA", 32'(RA), 32'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
